// File: rtl/stack_ctrl.sv
// stack_ctrl: multicycle control unit for the 8-bit stack CPU.
// Owns PC, IR and zero flag; sequences fetch/decode/pop/exe/push/store.
module stack_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem_data,
  input  logic       alu_zero,
  input  logic       stack_empty,
  input  logic       stack_full,
  output logic [4:0] mem_addr,
  output logic       mem_read,
  output logic       mem_write,
  output logic       push,
  output logic       pop,
  output logic       stack_src,
  output logic       a_load,
  output logic       b_load,
  output logic [1:0] alu_op,
  output logic [4:0] pc,
  output logic       zero_flag,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IF, S_ID, S_POP1, S_POP2,
    S_EXE, S_MRD, S_MWR, S_ERR
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       zf_q, zf_d;

  logic [2:0] opc;
  logic       is_alu, is_not, is_push;
  logic       is_pop, is_jmp, is_jz;

  assign opc     = ir_q[7:5];
  assign is_alu  = ~opc[2];
  assign is_not  = (opc == 3'b011);
  assign is_push = (opc == 3'b100);
  assign is_pop  = (opc == 3'b101);
  assign is_jmp  = (opc == 3'b110);
  assign is_jz   = (opc == 3'b111);

  assign alu_op    = ir_q[6:5];
  assign pc        = pc_q;
  assign zero_flag = zf_q;
  assign err       = (state_q == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      pc_q    <= '0;
      ir_q    <= '0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zf_q    <= zf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    zf_d      = zf_q;
    mem_addr  = ir_q[4:0];
    mem_read  = 1'b0;
    mem_write = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    stack_src = 1'b0;
    a_load    = 1'b0;
    b_load    = 1'b0;
    unique case (state_q)
      S_IF: begin
        mem_addr = pc_q;
        mem_read = 1'b1;
        ir_d     = mem_data;
        pc_d     = pc_q + 5'd1;
        state_d  = S_ID;
      end
      S_ID: begin
        state_d = S_IF;
        unique case (1'b1)
          is_alu:  state_d = S_POP1;
          is_push: state_d = S_MRD;
          is_pop:  state_d = S_MWR;
          is_jmp:  pc_d = ir_q[4:0];
          is_jz:   if (zf_q) pc_d = ir_q[4:0];
          default: state_d = S_IF;
        endcase
      end
      // first pop is the right operand; NOT has no left operand
      S_POP1: begin
        if (stack_empty) begin
          state_d = S_ERR;
        end else begin
          pop     = 1'b1;
          b_load  = 1'b1;
          state_d = is_not ? S_EXE : S_POP2;
        end
      end
      S_POP2: begin
        if (stack_empty) begin
          state_d = S_ERR;
        end else begin
          pop     = 1'b1;
          a_load  = 1'b1;
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (stack_full) begin
          state_d = S_ERR;
        end else begin
          push      = 1'b1;
          stack_src = 1'b1;
          zf_d      = alu_zero;
          state_d   = S_IF;
        end
      end
      S_MRD: begin
        if (stack_full) begin
          state_d = S_ERR;
        end else begin
          mem_read = 1'b1;
          push     = 1'b1;
          state_d  = S_IF;
        end
      end
      S_MWR: begin
        if (stack_empty) begin
          state_d = S_ERR;
        end else begin
          pop       = 1'b1;
          mem_write = 1'b1;
          state_d   = S_IF;
        end
      end
      S_ERR: state_d = S_ERR;
    endcase
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed bench with memory, 4-deep stack and ALU models
// around stack_ctrl.
module tb_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_data;
  logic       alu_zero;
  logic       stack_empty;
  logic       stack_full;
  logic [4:0] mem_addr;
  logic       mem_read, mem_write;
  logic       push, pop, stack_src;
  logic       a_load, b_load;
  logic [1:0] alu_op;
  logic [4:0] pc;
  logic       zero_flag, err;

  logic [7:0] mem [32];
  logic [7:0] stk [4];
  int         sp;
  logic [7:0] a_r, b_r, alu_res, tos;
  logic       force_full = 1'b0;
  int         pop_cnt, push_cnt, a_cnt, b_cnt, wr_cnt;
  logic [7:0] last_push, wr_data;
  logic [4:0] wr_addr;

  int checks = 0;
  int failures = 0;

  stack_ctrl dut (
    .clk(clk), .rst(rst), .mem_data(mem_data),
    .alu_zero(alu_zero), .stack_empty(stack_empty),
    .stack_full(stack_full), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_write(mem_write),
    .push(push), .pop(pop), .stack_src(stack_src),
    .a_load(a_load), .b_load(b_load), .alu_op(alu_op),
    .pc(pc), .zero_flag(zero_flag), .err(err)
  );

  always #5 clk = ~clk;

  assign mem_data    = mem[mem_addr];
  assign stack_empty = (sp == 0);
  assign stack_full  = (sp == 4) || force_full;
  assign tos         = (sp > 0) ? stk[sp-1] : 8'h00;
  assign alu_zero    = (alu_res == 8'h00);

  always_comb begin
    alu_res = 8'h00;
    case (alu_op)
      2'd0: alu_res = a_r + b_r;
      2'd1: alu_res = a_r - b_r;
      2'd2: alu_res = a_r & b_r;
      default: alu_res = ~b_r;
    endcase
  end

  always @(posedge clk) begin
    if (rst) begin
      sp <= 0; a_r <= 0; b_r <= 0;
      pop_cnt <= 0; push_cnt <= 0;
      a_cnt <= 0; b_cnt <= 0; wr_cnt <= 0;
      last_push <= 0; wr_data <= 0; wr_addr <= 0;
    end else begin
      if (a_load) begin a_r <= tos; a_cnt <= a_cnt + 1; end
      if (b_load) begin b_r <= tos; b_cnt <= b_cnt + 1; end
      if (pop) begin
        sp <= sp - 1;
        pop_cnt <= pop_cnt + 1;
      end
      if (push && sp < 4) begin
        stk[sp] <= stack_src ? alu_res : mem_data;
        last_push <= stack_src ? alu_res : mem_data;
        sp <= sp + 1;
        push_cnt <= push_cnt + 1;
      end
      if (mem_write) begin
        wr_addr <= mem_addr;
        wr_data <= tos;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    force_full = 1'b0;
  endtask

  task automatic load_sub(input logic [7:0] y);
    clr_mem();
    mem[0] = 8'h94; mem[1] = 8'h95;
    mem[2] = 8'h20; mem[3] = 8'hB6;
    mem[4] = 8'hE0;
    mem[20] = 8'd9; mem[21] = y;
  endtask

  initial begin
    // reset state
    clr_mem();
    step(1);
    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_mrd", mem_read, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_oth", {mem_write, push, pop, a_load, b_load}, 0);
    chk("rst_zf", zero_flag, 0);
    chk("rst_err", err, 0);

    // SUB 9-4 then POP 22, then JZ not taken
    load_sub(8'd4);
    do_reset();
    step(14);
    chk("sub_pc", pc, 4);
    chk("sub_wa", wr_addr, 22);
    chk("sub_wd", wr_data, 5);
    chk("sub_wc", wr_cnt, 1);
    chk("sub_zf", zero_flag, 0);
    chk("sub_sp", sp, 0);
    chk("sub_if", mem_read, 1);
    step(2);
    chk("jz_nt_pc", pc, 5);

    // SUB 9-9 gives zero, JZ taken
    load_sub(8'd9);
    do_reset();
    step(14);
    chk("sub0_wd", wr_data, 0);
    chk("sub0_zf", zero_flag, 1);
    step(1);
    chk("jz_if_pc", pc, 5);
    step(1);
    chk("jz_t_pc", pc, 0);
    chk("jz_t_zf", zero_flag, 1);

    // NOT of 0x0F
    clr_mem();
    mem[0] = 8'h8A; mem[1] = 8'h60; mem[10] = 8'h0F;
    do_reset();
    step(7);
    chk("not_pop", pop_cnt, 1);
    chk("not_b", b_cnt, 1);
    chk("not_a", a_cnt, 0);
    chk("not_push", push_cnt, 2);
    chk("not_res", last_push, 8'hF0);
    chk("not_pc", pc, 2);
    chk("not_if", mem_read, 1);
    chk("not_zf", zero_flag, 0);

    // JMP 31, then JMP 3 from pc=31
    clr_mem();
    mem[0] = 8'hDF; mem[31] = 8'hC3;
    do_reset();
    step(2);
    chk("jw_pc31", pc, 31);
    step(1);
    chk("jw_wrap", pc, 0);
    chk("jw_id_strb",
        {mem_read, mem_write, push, pop, a_load, b_load}, 0);
    step(1);
    chk("jw_pc3", pc, 3);

    // ADD with a single stack entry
    clr_mem();
    mem[0] = 8'h8A; mem[1] = 8'h00; mem[10] = 8'h33;
    do_reset();
    step(5);
    chk("f1_pop1", {pop, b_load}, 2'b11);
    step(1);
    chk("f1_pop2", {pop, a_load, b_load, push}, 0);
    chk("f1_err0", err, 0);
    step(1);
    chk("f1_err1", err, 1);
    step(10);
    chk("f1_hold", err, 1);
    chk("f1_pc", pc, 2);
    chk("f1_strb",
        {mem_read, mem_write, push, pop, a_load, b_load}, 0);
    do_reset();
    chk("f1_rst_err", err, 0);
    chk("f1_rst_pc", pc, 0);
    chk("f1_rst_mrd", mem_read, 1);

    // PUSH into a full stack
    clr_mem();
    mem[0] = 8'h8A; mem[10] = 8'h33;
    do_reset();
    force_full = 1'b1;
    step(2);
    chk("f2_mrd", {mem_read, push}, 0);
    step(1);
    chk("f2_err", err, 1);
    chk("f2_pushes", push_cnt, 0);
    force_full = 1'b0;

    // reset during POP2 with zero_flag set
    clr_mem();
    mem[0] = 8'h94; mem[1] = 8'h94; mem[2] = 8'h20;
    mem[3] = 8'h94; mem[4] = 8'h94; mem[5] = 8'h00;
    mem[20] = 8'd9;
    do_reset();
    step(11);
    chk("mr_zf1", zero_flag, 1);
    step(9);
    chk("mr_pop2", {pop, a_load}, 2'b11);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mr_pc", pc, 0);
    chk("mr_zf", zero_flag, 0);
    chk("mr_if", {mem_read, mem_addr}, {1'b1, 5'd0});
    chk("mr_push", push, 0);
    step(1);
    chk("mr_id_push", push, 0);
    chk("mr_id_pc", pc, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
